// File: rtl/amp_spi_param.sv
// amp_spi_param -- parametrised SPI programmer for the programmable pre-amplifier.
//
// Shifts a WIDTH-bit gain word out MSB-first on SPI_MOSI_AMP. The SPI clock
// half-period is CLK_DIV system clocks. The block also drives the amplifier
// chip-select and shutdown pins.
//
// Optional feature macro: AMP_SPI_READBACK_EN
//   defined   : the word echoed on SPI_MISO_AMP is captured and presented on
//               RD_WORD at the end of each frame.
//   undefined : SPI_MISO_AMP is ignored, RD_WORD is tied to 0, and no
//               capture register is built.
//
// Parameters
//   WIDTH   (2..32)  frame length in bits
//   CLK_DIV (1..255) SPI clock half-period in clk cycles
//
// Ports
//   clk           system clock (rising edge)
//   reset         asynchronous reset, active low
//   GO_AMP        start request, accepted while BUSY_AMP=0
//   GAIN_WORD     word to transmit, latched on the accepting edge
//   SHDN_REQ      requested amplifier shutdown level
//   SPI_MISO_AMP  serial data from the amplifier
//   BUSY_AMP      frame in progress
//   DONE_AMP      one-cycle pulse at end of frame
//   SPI_CLK_AMP   SPI clock, idles low
//   SPI_MOSI_AMP  serial data to the amplifier
//   AMP_CS        chip select, active low
//   AMP_SHDN      registered copy of SHDN_REQ (1 while in reset)
//   RD_WORD       word captured from MISO during the last frame
module amp_spi_param #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             GO_AMP,
    input  logic [WIDTH-1:0] GAIN_WORD,
    input  logic             SHDN_REQ,
    input  logic             SPI_MISO_AMP,
    output logic             BUSY_AMP,
    output logic             DONE_AMP,
    output logic             SPI_CLK_AMP,
    output logic             SPI_MOSI_AMP,
    output logic             AMP_CS,
    output logic             AMP_SHDN,
    output logic [WIDTH-1:0] RD_WORD
);

    localparam int         CNT_W    = $clog2(WIDTH + 1);
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_HOLD, S_END
    } state_e;

    state_e           state_q;
    logic [7:0]       div_q;
    logic [CNT_W-1:0] bit_q;
    logic [WIDTH-1:0] sreg_q;
    logic             cs_q, sclk_q, busy_q, done_q, shdn_q;

    // A phase ends when the down-counter reaches zero.
    logic div_zero;
    assign div_zero = (div_q == 8'd0);

    // MOSI is taken directly from the MSB of the shift register. The register
    // is cleared outside a frame, so MOSI idles low with no extra flop.
    assign SPI_MOSI_AMP = sreg_q[WIDTH-1];
    assign AMP_CS       = cs_q;
    assign SPI_CLK_AMP  = sclk_q;
    assign BUSY_AMP     = busy_q;
    assign DONE_AMP     = done_q;
    assign AMP_SHDN     = shdn_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= 8'd0;
            bit_q   <= '0;
            sreg_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shdn_q  <= 1'b1;
        end else begin
            shdn_q <= SHDN_REQ;
            done_q <= 1'b0;
            case (state_q)
                // END behaves like IDLE for acceptance, which allows back-to-back frames.
                S_IDLE, S_END: begin
                    sclk_q <= 1'b0;
                    if (GO_AMP) begin
                        state_q <= S_SETUP;
                        sreg_q  <= GAIN_WORD;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= DIV_LOAD;
                        bit_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        sreg_q  <= '0;
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (div_zero) begin
                        state_q <= S_SHIFT_HI;
                        sclk_q  <= 1'b1;
                        div_q   <= DIV_LOAD;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (div_zero) begin
                        sclk_q <= 1'b0;
                        div_q  <= DIV_LOAD;
                        if (bit_q == LAST_BIT) begin
                            // The low phase after the last bit is spent in HOLD.
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_SHIFT_LO;
                            sreg_q  <= sreg_q << 1;
                            bit_q   <= bit_q + CNT_W'(1);
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                S_SHIFT_LO: begin
                    if (div_zero) begin
                        state_q <= S_SHIFT_HI;
                        sclk_q  <= 1'b1;
                        div_q   <= DIV_LOAD;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (div_zero) begin
                        state_q <= S_END;
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sreg_q  <= '0;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AMP_SPI_READBACK_EN
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] rd_q;

    // MISO is sampled on the clk edge that raises SPI_CLK_AMP. That is the
    // same condition that moves SETUP or SHIFT_LO into SHIFT_HI.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q <= '0;
            rd_q  <= '0;
        end else begin
            if ((state_q == S_SETUP || state_q == S_SHIFT_LO) && div_zero)
                cap_q <= {cap_q[WIDTH-2:0], SPI_MISO_AMP};
            if (state_q == S_HOLD && div_zero)
                rd_q <= cap_q;
        end
    end
    assign RD_WORD = rd_q;
`else
    logic unused_miso;
    assign unused_miso = SPI_MISO_AMP;
    assign RD_WORD     = '0;
`endif

endmodule

// File: tb/tb_amp_spi_param.sv
module tb_amp_spi_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       go, shdn_req, miso;
    logic [7:0] gain;
    logic       busy, done, sclk, mosi, cs, shdn;
    logic [7:0] rd;

    // WIDTH=16, CLK_DIV=1 instance
    logic        go16;
    logic        miso16 = 1'b0;
    logic [15:0] gain16;
    logic        busy16, done16, sclk16, mosi16, cs16, shdn16;
    logic [15:0] rd16;

    int total = 0;
    int bad = 0;

    logic [7:0] echo_pat = 8'hA5;
    int         k = 0;

`ifdef AMP_SPI_READBACK_EN
    localparam logic [7:0] EXP_RD = 8'hA5;
`else
    localparam logic [7:0] EXP_RD = 8'h00;
`endif

    amp_spi_param dut (
        .clk(clk), .reset(reset), .GO_AMP(go), .GAIN_WORD(gain), .SHDN_REQ(shdn_req),
        .SPI_MISO_AMP(miso), .BUSY_AMP(busy), .DONE_AMP(done), .SPI_CLK_AMP(sclk),
        .SPI_MOSI_AMP(mosi), .AMP_CS(cs), .AMP_SHDN(shdn), .RD_WORD(rd));

    amp_spi_param #(.WIDTH(16), .CLK_DIV(1)) dut16 (
        .clk(clk), .reset(reset), .GO_AMP(go16), .GAIN_WORD(gain16), .SHDN_REQ(shdn_req),
        .SPI_MISO_AMP(miso16), .BUSY_AMP(busy16), .DONE_AMP(done16), .SPI_CLK_AMP(sclk16),
        .SPI_MOSI_AMP(mosi16), .AMP_CS(cs16), .AMP_SHDN(shdn16), .RD_WORD(rd16));

    // Amplifier echo model: the k-th SPI clock rise of a frame sees bit 7-k of echo_pat.
    always @(posedge sclk or posedge cs) begin
        if (cs) k <= 0;
        else    k <= k + 1;
    end
    assign miso = (k < 8) ? echo_pat[7-k] : 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Runs one 8-bit frame from idle. It samples each cycle at the falling edge;
    // cycle n is the one that follows edge En.
    task automatic run8(input logic [7:0] w, input int retrig, input bit tog,
                        output int cs_low, output int done_at, output int ndone,
                        output int rise1, output logic [7:0] bits, output logic [7:0] rd_done,
                        output logic busy1, output logic busy_done, output logic [3:0] shobs);
        logic prev;
        cs_low = 0; done_at = -1; ndone = 0; rise1 = -1; bits = 8'h00;
        rd_done = 8'h00; busy1 = 1'b0; busy_done = 1'b1; shobs = 4'h0; prev = 1'b0;
        @(negedge clk);
        gain = w; go = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            go   = (n == retrig);
            gain = ~w;
            if (!cs) cs_low++;
            if (sclk && !prev) begin
                if (rise1 < 0) rise1 = n;
                bits = {bits[6:0], mosi};
            end
            prev = sclk;
            if (done) begin
                ndone++; done_at = n; rd_done = rd; busy_done = busy;
            end
            if (n == 1) busy1 = busy;
            if (tog && n >= 20 && n <= 23) begin
                shobs = {shobs[2:0], shdn};
                shdn_req = (n == 20 || n == 22);
            end
        end
        go = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (cs !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b exp=1", cs); end
        total++; if (shdn !== 1'b1) begin bad++; $display("FAIL rst_shdn got=%b exp=1", shdn); end
        total++; if ({sclk, mosi, busy, done} !== 4'b0000) begin bad++;
            $display("FAIL rst_sclk_mosi_busy_done got=%b exp=0000", {sclk, mosi, busy, done}); end
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL rst_rd got=%h exp=00", rd); end
        total++; if (cs16 !== 1'b1) begin bad++; $display("FAIL rst_cs16 got=%b exp=1", cs16); end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (shdn !== 1'b0) begin bad++; $display("FAIL rst_shdn_follow got=%b exp=0", shdn); end
        total++; if ({cs, busy} !== 2'b10) begin bad++; $display("FAIL idle_cs_busy got=%b exp=10", {cs, busy}); end
    endtask

    task automatic test_frame();
        int cl, da, nd, r1; logic [7:0] b, r; logic b1, bd; logic [3:0] so;
        run8(8'h11, 0, 1'b0, cl, da, nd, r1, b, r, b1, bd, so);
        total++; if (b !== 8'h11) begin bad++; $display("FAIL frame_mosi got=%h exp=11", b); end
        total++; if (cl != 68) begin bad++; $display("FAIL frame_cs_low got=%0d exp=68", cl); end
        total++; if (da != 69) begin bad++; $display("FAIL frame_done_at got=%0d exp=69", da); end
        total++; if (nd != 1) begin bad++; $display("FAIL frame_done_count got=%0d exp=1", nd); end
        total++; if (r1 != 5) begin bad++; $display("FAIL frame_first_rise got=%0d exp=5", r1); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL frame_busy_e1 got=%b exp=1", b1); end
        total++; if (bd !== 1'b0) begin bad++; $display("FAIL frame_busy_end got=%b exp=0", bd); end
        total++; if (r !== EXP_RD) begin bad++; $display("FAIL frame_rd got=%h exp=%h", r, EXP_RD); end
    endtask

    task automatic test_retrigger();
        int cl, da, nd, r1; logic [7:0] b, r; logic b1, bd; logic [3:0] so;
        run8(8'h5A, 30, 1'b0, cl, da, nd, r1, b, r, b1, bd, so);
        total++; if (b !== 8'h5A) begin bad++; $display("FAIL retrig_mosi got=%h exp=5a", b); end
        total++; if (nd != 1 || da != 69) begin bad++;
            $display("FAIL retrig_done got=%0d@%0d exp=1@69", nd, da); end
    endtask

    task automatic test_back_to_back();
        int nd, d1, d2, cs_hi; bit seen;
        nd = 0; d1 = -1; d2 = -1; cs_hi = 0; seen = 1'b0;
        @(negedge clk);
        gain = 8'h33; go = 1'b1;
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) d1 = n;
                if (nd == 2) d2 = n;
            end
            if (n <= 138 && cs) cs_hi++;
        end
        go = 1'b0;
        total++; if (nd != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
        total++; if (d1 != 69 || d2 != 138) begin bad++;
            $display("FAIL b2b_done_at got=%0d,%0d exp=69,138", d1, d2); end
        total++; if (cs_hi != 2) begin bad++; $display("FAIL b2b_cs_high got=%0d exp=2", cs_hi); end
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL b2b_third_done got=0 exp=1"); end
        @(negedge clk);
    endtask

    task automatic test_wide();
        int cl, da, tr; logic [15:0] b; logic prev;
        cl = 0; da = -1; tr = 0; b = 16'h0; prev = 1'b0;
        @(negedge clk);
        gain16 = 16'hBEEF; go16 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            go16 = 1'b0; gain16 = 16'h0000;
            if (!cs16) cl++;
            if (sclk16 && !prev) b = {b[14:0], mosi16};
            if (n >= 2 && n <= 33 && sclk16 != prev) tr++;
            prev = sclk16;
            if (done16) da = n;
        end
        total++; if (b !== 16'hBEEF) begin bad++; $display("FAIL wide_mosi got=%h exp=beef", b); end
        total++; if (cl != 33) begin bad++; $display("FAIL wide_cs_low got=%0d exp=33", cl); end
        total++; if (tr != 32) begin bad++; $display("FAIL wide_toggles got=%0d exp=32", tr); end
        total++; if (da != 34) begin bad++; $display("FAIL wide_done_at got=%0d exp=34", da); end
    endtask

    task automatic test_reset_mid();
        int nd, cl, da, nd2, r1; logic [7:0] b, r; logic b1, bd; logic [3:0] so;
        nd = 0;
        @(negedge clk);
        gain = 8'h11; go = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            go = 1'b0;
        end
        // Cycle 30 falls in the high phase of bit 3.
        total++; if ({cs, sclk} !== 2'b01) begin bad++;
            $display("FAIL rmid_pre got=%b exp=01", {cs, sclk}); end
        reset = 1'b0;
        #1;
        total++; if ({cs, shdn, sclk, mosi, busy} !== 5'b11000) begin bad++;
            $display("FAIL rmid_outputs got=%b exp=11000", {cs, shdn, sclk, mosi, busy}); end
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL rmid_rd got=%h exp=00", rd); end
        @(negedge clk); reset = 1'b1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done) nd++;
        end
        total++; if (nd != 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", nd); end
        run8(8'h11, 0, 1'b0, cl, da, nd2, r1, b, r, b1, bd, so);
        total++; if (cl != 68 || da != 69) begin bad++;
            $display("FAIL rmid_next_frame got=%0d/%0d exp=68/69", cl, da); end
    endtask

    task automatic test_shdn();
        int cl, da, nd, r1; logic [7:0] b, r; logic b1, bd; logic [3:0] so;
        run8(8'hC3, 0, 1'b1, cl, da, nd, r1, b, r, b1, bd, so);
        total++; if (so !== 4'b0101) begin bad++; $display("FAIL shdn_follow got=%b exp=0101", so); end
        total++; if (cl != 68 || da != 69 || b !== 8'hC3) begin bad++;
            $display("FAIL shdn_frame got=%0d/%0d/%h exp=68/69/c3", cl, da, b); end
    endtask

    initial begin
        go = 1'b0; gain = 8'h00; shdn_req = 1'b0; go16 = 1'b0; gain16 = 16'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame();
        test_retrigger();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        test_shdn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
